// File: rtl/perceptron_pkg.sv
// Shared widths, FSM state type and the error arithmetic for the perceptron trainer.
package perceptron_pkg;

  localparam int ARGW = 8;
  localparam int ARGD = 2;
  localparam int RESW = 8;
  localparam int ERRW = 16;
  localparam int FBKW = 16;
  localparam int FBKD = 2;

  typedef enum logic [2:0] {
    IDLE,
    ARG,
    RES,
    ERR,
    FBK
  } state_t;

  // tgt - res with both operands zero-extended, so the result always fits in ERRW.
  function automatic logic signed [ERRW-1:0] err_calc(input logic [RESW-1:0] tgt,
                                                      input logic [RESW-1:0] res);
    logic signed [ERRW-1:0] t;
    logic signed [ERRW-1:0] r;
    t = $signed({{(ERRW-RESW){1'b0}}, tgt});
    r = $signed({{(ERRW-RESW){1'b0}}, res});
    return t - r;
  endfunction

endpackage

// File: rtl/perceptron_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  // Count completions, holding at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Supervisor that walks one sample at a time through a perceptron's
// argument/result/error/feedback streams and keeps per-epoch statistics.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int ARGW = perceptron_pkg::ARGW,
  parameter int ARGD = perceptron_pkg::ARGD,
  parameter int RESW = perceptron_pkg::RESW,
  parameter int ERRW = perceptron_pkg::ERRW,
  parameter int FBKW = perceptron_pkg::FBKW,
  parameter int FBKD = perceptron_pkg::FBKD,
  parameter int TOL  = 0,
  parameter int CNTW = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      smp_valid,
  output logic                      smp_ready,
  input  logic [ARGD*ARGW+RESW-1:0] smp_data,
  output logic                      arg_valid,
  input  logic                      arg_ready,
  output logic [ARGD*ARGW-1:0]      arg_data,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [RESW-1:0]           res_data,
  output logic                      err_valid,
  input  logic                      err_ready,
  output logic [ERRW-1:0]           err_data,
  input  logic                      fbk_valid,
  output logic                      fbk_ready,
  input  logic [FBKD*FBKW-1:0]      fbk_data,
  output logic [CNTW-1:0]           cnt,
  output logic [CNTW-1:0]           hit
);

  localparam int AW = ARGD * ARGW;
  localparam logic [ERRW:0] TOL_V = (ERRW+1)'(TOL);
  localparam logic [ERRW:0] ONE   = (ERRW+1)'(1);

  state_t           state;
  logic             mode;
  logic [RESW-1:0]  tgt_q;
  logic [ERRW-1:0]  err_new;
  logic [ERRW:0]    fin_err;
  logic [ERRW:0]    err_mag;
  logic             done;
  logic             hit_inc;
  logic             unused_fbk;

  // Feedback is drained and discarded.
  assign unused_fbk = ^fbk_data;

  assign err_new = err_calc(tgt_q, res_data);

  // Sample sequencer: each handshake output is set on entry to its state.
  // NOTE: state and outputs use non-blocking assignments so every read in this
  // block sees the pre-edge value, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      smp_ready <= 1'b0;
      arg_valid <= 1'b0;
      res_ready <= 1'b0;
      err_valid <= 1'b0;
      fbk_ready <= 1'b0;
      arg_data  <= '0;
      err_data  <= '0;
      mode      <= 1'b0;
      tgt_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (smp_ready && smp_valid) begin
            arg_data  <= smp_data[AW-1:0];
            tgt_q     <= smp_data[AW +: RESW];
            mode      <= en;
            smp_ready <= 1'b0;
            arg_valid <= 1'b1;
            state     <= ARG;
          end else begin
            smp_ready <= 1'b1;
          end
        end
        ARG: begin
          if (arg_ready) begin
            arg_valid <= 1'b0;
            res_ready <= 1'b1;
            state     <= RES;
          end
        end
        RES: begin
          if (res_valid) begin
            err_data  <= err_new;
            res_ready <= 1'b0;
            if (mode) begin
              err_valid <= 1'b1;
              state     <= ERR;
            end else begin
              smp_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        ERR: begin
          if (err_ready) begin
            err_valid <= 1'b0;
            fbk_ready <= 1'b1;
            state     <= FBK;
          end
        end
        FBK: begin
          if (fbk_valid) begin
            fbk_ready <= 1'b0;
            smp_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Detect sample completion and pick the error that belongs to it.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    done    = 1'b0;
    fin_err = '0;
    if ((state == RES) && res_valid && !mode) begin
      done    = 1'b1;
      fin_err = {err_new[ERRW-1], err_new};
    end else if ((state == FBK) && fbk_valid) begin
      done    = 1'b1;
      fin_err = {err_data[ERRW-1], err_data};
    end
  end

  // One extra bit keeps the magnitude of the most-negative error representable.
  assign err_mag = fin_err[ERRW] ? (~fin_err + ONE) : fin_err;
  assign hit_inc = done && (err_mag <= TOL_V);

  sat_counter #(.WIDTH(CNTW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (done),
    .cnt (cnt)
  );

  sat_counter #(.WIDTH(CNTW)) u_hit (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (hit_inc),
    .cnt (hit)
  );

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
Hardware supervisor that drives a perceptron over its four streaming ports: issues arguments, collects results, computes and returns the error, and drains feedback. Sits between a sample source (argument plus target) and a perceptron instance, and replaces bench-side training loops with synthesizable logic. Keeps per-epoch statistics of processed samples and of samples within error tolerance.

Parameters:
ARGW, 8, bits per argument element
ARGD, 2, argument elements per sample
RESW, 8, result/target width (unsigned)
ERRW, 16, error width (signed, two's complement)
FBKW, 16, bits per feedback element
FBKD, 2, feedback elements per sample
TOL, 0, max |err| counted as a hit
CNTW, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  1 = training (send err, drain fbk); 0 = inference only
clr  in  1  synchronous clear of statistics counters
smp_valid  in  1  sample valid
smp_ready  out  1  sample ready
smp_data  in  ARGD*ARGW+RESW  {tgt[RESW-1:0], arg[ARGD-1:0][ARGW-1:0]}, arg in LSBs
arg_valid  out  1  argument valid to perceptron
arg_ready  in  1  argument ready
arg_data  out  ARGD*ARGW  argument
res_valid  in  1  result valid from perceptron
res_ready  out  1  result ready
res_data  in  RESW  result
err_valid  out  1  error valid to perceptron
err_ready  in  1  error ready
err_data  out  ERRW  signed error
fbk_valid  in  1  feedback valid
fbk_ready  out  1  feedback ready
fbk_data  in  FBKD*FBKW  feedback (discarded)
cnt  out  CNTW  samples completed since reset/clr
hit  out  CNTW  completed samples with |err| <= TOL

Behaviour:
- Handshakes: transfer on valid&ready at posedge clk; an asserted valid is held with stable data until the transfer.
- Reset (rst=1, async): state IDLE; smp_ready, arg_valid, res_ready, err_valid, fbk_ready = 0; arg_data, err_data = 0; cnt = hit = 0. Reset mid-sample abandons it with no further handshakes.
- FSM states: IDLE, ARG, RES, ERR, FBK.
- IDLE: smp_ready = 1 (0 while rst). On smp transfer: latch arg, tgt and en (mode = en); go to ARG. en changes mid-sample have no effect.
- ARG: arg_valid = 1. On arg transfer go to RES. First arg_valid is the cycle after smp transfer.
- RES: res_ready = 1. On res transfer: err_data <= sign-extend({1'b0,tgt}) - sign-extend({1'b0,res}) to ERRW (range -255..+255 at defaults, no overflow). If mode = 1 go to ERR, else complete the sample and go to IDLE.
- ERR: err_valid = 1. On err transfer go to FBK.
- FBK: fbk_ready = 1. On fbk transfer complete the sample and go to IDLE.
- At most one sample in flight; no overlap between samples.
- Sample completion: cnt += 1; hit += 1 if |err| <= TOL. |err| uses the magnitude with ERRW+1 bits, so the most-negative value is handled. Both counters saturate at all-ones.
- clr: counters become 0 next cycle. clr takes priority over a simultaneous increment, which is dropped.
- Zero-wait path (all peers ready): training sample takes 5 cycles from smp transfer to IDLE; inference sample takes 3.

Decomposition:
- Package perceptron_pkg: default widths (ARGW, ARGD, RESW, ERRW, FBKW, FBKD).
- Package perceptron_pkg: state enum {IDLE, ARG, RES, ERR, FBK}.
- Package perceptron_pkg: function err_calc(tgt, res) returning signed ERRW.
- One sub-module, sat_counter (WIDTH, clr, inc, cnt), instantiated for cnt and hit.

Test Plan:
- Inference, en=0, smp {tgt=8'hff, arg=16'hffff}, res=8'h7f, all peers ready → arg_data=16'hffff one cycle after smp; err_data=16'h0080; no err_valid; cnt=1, hit=0.
- Training, en=1, tgt=8'h00, res=8'hff → err_data=16'hff01 (-255) held under err_ready=0 for 3 cycles; fbk_ready only after err transfer; cnt=1.
- Back-pressure: arg_ready low for 4 cycles → arg_valid and arg_data stable, smp_ready=0 throughout; sample completes after release.
- AND loop with a perceptron instance: 10 training epochs over {0000,00ff,ff00,ffff}/{00,00,00,ff}, then clr and one en=0 epoch → cnt=4, hit=4.
- clr asserted in the same cycle as sample completion → cnt=0, hit=0. Saturation: preload cnt near all-ones (CNTW=4 build), complete 3 samples → cnt=4'hf.
- rst asserted while in ERR → err_valid drops immediately; after release smp_ready=1; a new sample runs normally.
